axi_counter_core: RTL
=====================

# axi_counter_core

Programmable timer/counter driven by the AXI register block's register array. Consumes the `BRAM_QUANTITY` 32-bit configuration registers and runs a prescaled up/down counter with reload, one-shot, compare and interrupt logic. Produces the live count and event outputs for the top level and the interrupt line. Registers carry no write strobe, so commands are issued by toggling bits and detected here by edge comparison.

## Interface
- `DATA_WIDTH`, 32: register and counter width.
- `BRAM_QUANTITY`, 6: number of registers in `regs_i`; must be ≥ 6.

- `clk`  in  1  single clock.
- `areset`  in  1  reset, synchronous, active-high.
- `regs_i`  in  `DATA_WIDTH` × [0:BRAM_QUANTITY-1]  register array from the AXI register block.
- `count_o`  out  `DATA_WIDTH`  current count, registered.
- `running_o`  out  1  high in RUN.
- `ovf_o`  out  1  one-cycle pulse on wrap, reload or one-shot end.
- `match_o`  out  1  one-cycle pulse when count becomes equal to COMPARE.
- `irq_o`  out  1  sticky interrupt.

## Operation
- Register map by index: 0 CTRL, 1 PRESCALE, 2 LIMIT, 3 COMPARE, 4 LOAD, 5 CMD.
- CTRL bits: [0] EN, [1] DIR (0 up, 1 down), [2] ONESHOT, [3] IRQ_EN_OVF, [4] IRQ_EN_MATCH.
- CMD bits: [0] LOAD_T, [1] IRQCLR_T. A command fires on any change of the bit versus its shadow flop. Shadows reset to 0, so a nonzero reset-time bit fires once in the first cycle after reset.
- States: IDLE, RUN, DONE.
  - IDLE→RUN when EN=1.
  - RUN→IDLE when EN=0. Count is held.
  - RUN→DONE on terminal tick with ONESHOT=1.
  - DONE→IDLE when EN=0. DONE ignores EN=1.
- Prescaler:
  - Counts 0..PRESCALE in RUN only and emits `tick` at PRESCALE. PRESCALE=0 gives a tick every cycle.
  - Clears on entry to RUN and on LOAD.
- Up mode, on tick:
  - If count ≥ LIMIT: terminal. Count goes to 0 (ONESHOT=0) or holds (ONESHOT=1), and `ovf_o` pulses.
  - Otherwise count+1.
- Down mode, on tick:
  - If count = 0: terminal. Count goes to LIMIT (ONESHOT=0) or holds at 0 (ONESHOT=1), and `ovf_o` pulses.
  - Otherwise count−1.
- Arithmetic is unsigned, `DATA_WIDTH` bits. No other wrap path exists.
- `match_o` pulses in the cycle after `count_o` changes to a value equal to COMPARE. Loading COMPARE's value also pulses it. A held count does not re-pulse.
- `irq_o`:
  - Set by `ovf_o`&IRQ_EN_OVF or by `match_o`&IRQ_EN_MATCH.
  - Cleared by IRQCLR_T.
  - Set wins on the same cycle.
- LOAD_T:
  - count ← LOAD, in any state.
  - Overrides a tick in the same cycle; the prescaler clears.
  - In DONE, state goes to IDLE.
- DIR or LIMIT changes take effect at the next tick.

## Timing
- All outputs are registered. Reset values: `count_o`=0, `running_o`=0, `ovf_o`=0, `match_o`=0, `irq_o`=0. State is IDLE; prescaler and shadows are 0.
- `regs_i` is sampled every cycle with no extra staging. An AXI write lands in `regs_i` one cycle after the write handshake.
- EN rising at cycle N: RUN and `running_o` at N+1. First count change at N+1+PRESCALE+1.
- A count change and its `ovf_o` appear in the same cycle. `match_o` and the `irq_o` set follow one cycle later.
- A LOAD toggle seen at cycle N gives `count_o`=LOAD at N+1.
- `areset` asserted mid-count: all state returns to reset values at the next edge.

## Structure
- Package `counter_pkg`:
  - register index localparams;
  - CTRL/CMD bit positions;
  - `state_t` enum {IDLE, RUN, DONE}.
- Sub-module `counter_prescaler`: enable, clear, PRESCALE in; `tick` out.
- The top holds the FSM, counter, command edge detect, compare and irq.
- Expected size: ~200 lines.

## Test plan
- Reset, then LIMIT=3, PRESCALE=0, CTRL=0x1: count 0,1,2,3,0. `ovf_o` pulses with the 3→0 step; `irq_o` stays 0.
- PRESCALE=2, LIMIT=5, CTRL=0x9 (EN, IRQ_EN_OVF): count changes every 3 cycles. `irq_o`=1 after the first wrap. IRQCLR_T toggle → `irq_o`=0.
- LOAD=4, LOAD_T toggle, CTRL=0x7 (down, one-shot): 4,3,2,1,0, one `ovf_o`, state DONE, count held 0. EN→0 gives IDLE.
- COMPARE=2, CTRL=0x11, LIMIT=10: single `match_o` after count reaches 2, `irq_o`=1. EN cleared at count 5 → count held, no further match.
- LOAD_T toggle on the same cycle as a tick: count=LOAD, no increment. IRQCLR_T toggled on the same cycle as an irq set: `irq_o` remains 1.
- `areset` pulsed while RUN at count 7: all outputs 0 and state IDLE next cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared register map, bit positions and FSM state type for the
// AXI-driven timer/counter.
package counter_pkg;

    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_PRESCALE = 1;
    localparam int unsigned REG_LIMIT    = 2;
    localparam int unsigned REG_COMPARE  = 3;
    localparam int unsigned REG_LOAD     = 4;
    localparam int unsigned REG_CMD      = 5;

    localparam int unsigned CTRL_EN           = 0;
    localparam int unsigned CTRL_DIR          = 1;
    localparam int unsigned CTRL_ONESHOT      = 2;
    localparam int unsigned CTRL_IRQ_EN_OVF   = 3;
    localparam int unsigned CTRL_IRQ_EN_MATCH = 4;
    localparam int unsigned CTRL_USED_BITS    = 5;

    localparam int unsigned CMD_LOAD_T     = 0;
    localparam int unsigned CMD_IRQCLR_T   = 1;
    localparam int unsigned CMD_USED_BITS  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: counts 0..prescale while enabled and emits tick on the
// terminal value.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] prescale,
    output logic                  tick
);

    logic [DATA_WIDTH-1:0] cnt_q;

    // >= rather than == so a PRESCALE lowered mid-count cannot strand the
    // counter for a full 2^DATA_WIDTH wrap.
    assign tick = enable && (cnt_q >= prescale);

    always_ff @(posedge clk) begin
        if (areset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi_counter_core.sv
// Programmable up/down timer with reload, one-shot, compare and sticky
// interrupt, configured from the AXI register array.
module axi_counter_core
    import counter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BRAM_QUANTITY = 6
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] regs_i [0:BRAM_QUANTITY-1],
    output logic [DATA_WIDTH-1:0] count_o,
    output logic                  running_o,
    output logic                  ovf_o,
    output logic                  match_o,
    output logic                  irq_o
);

    logic [DATA_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] prescale;
    logic [DATA_WIDTH-1:0] limit;
    logic [DATA_WIDTH-1:0] compare;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] cmd;

    logic                  en;
    logic                  dir_down;
    logic                  oneshot;
    logic [1:0]            cmd_shadow_q;
    logic                  load_fire;
    logic                  irqclr_fire;
    logic                  irq_set;

    state_t                state_q;
    state_t                state_d;
    logic                  count_en;
    logic                  running_d;
    logic                  tick;
    logic                  terminal;
    logic                  changed_q;
    logic [DATA_WIDTH-1:0] count_d;
    logic                  unused_bits;

    assign ctrl     = regs_i[REG_CTRL];
    assign prescale = regs_i[REG_PRESCALE];
    assign limit    = regs_i[REG_LIMIT];
    assign compare  = regs_i[REG_COMPARE];
    assign load_val = regs_i[REG_LOAD];
    assign cmd      = regs_i[REG_CMD];

    assign en       = ctrl[CTRL_EN];
    assign dir_down = ctrl[CTRL_DIR];
    assign oneshot  = ctrl[CTRL_ONESHOT];

    // Registers have no write strobe: a command is any flip of its CMD bit.
    assign load_fire   = cmd[CMD_LOAD_T]   ^ cmd_shadow_q[0];
    assign irqclr_fire = cmd[CMD_IRQCLR_T] ^ cmd_shadow_q[1];
    assign irq_set     = (ovf_o & ctrl[CTRL_IRQ_EN_OVF]) | (match_o & ctrl[CTRL_IRQ_EN_MATCH]);

    always_comb begin
        unused_bits = ^{ctrl[DATA_WIDTH-1:CTRL_USED_BITS], cmd[DATA_WIDTH-1:CMD_USED_BITS]};
        for (int unsigned i = 6; i < BRAM_QUANTITY; i++) begin
            unused_bits = unused_bits ^ (^regs_i[i]);
        end
    end

    // Held at zero whenever not counting, which also covers clear-on-entry to RUN.
    counter_prescaler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .areset  (areset),
        .enable  (count_en),
        .clear   (load_fire || !count_en),
        .prescale(prescale),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (terminal && oneshot) begin
                    state_d = DONE;
                end
            end
            DONE: if (load_fire || !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_en  = (state_q == RUN) && en;
        running_d = (state_d == RUN);
    end

    always_comb begin
        count_d  = count_o;
        terminal = 1'b0;
        if (load_fire) begin
            count_d = load_val;
        end else if (tick) begin
            if (!dir_down) begin
                if (count_o >= limit) begin
                    terminal = 1'b1;
                    count_d  = oneshot ? count_o : '0;
                end else begin
                    count_d = count_o + DATA_WIDTH'(1);
                end
            end else begin
                if (count_o == '0) begin
                    terminal = 1'b1;
                    count_d  = oneshot ? '0 : limit;
                end else begin
                    count_d = count_o - DATA_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            count_o      <= '0;
            running_o    <= 1'b0;
            ovf_o        <= 1'b0;
            match_o      <= 1'b0;
            irq_o        <= 1'b0;
            changed_q    <= 1'b0;
            cmd_shadow_q <= '0;
        end else begin
            count_o      <= count_d;
            running_o    <= running_d;
            ovf_o        <= terminal;
            changed_q    <= load_fire || (count_d != count_o);
            match_o      <= changed_q && (count_o == compare);
            cmd_shadow_q <= {cmd[CMD_IRQCLR_T], cmd[CMD_LOAD_T]};
            if (irq_set) begin
                irq_o <= 1'b1;
            end else if (irqclr_fire) begin
                irq_o <= 1'b0;
            end
        end
    end

endmodule
